// File: rtl/spike_event_fifo.sv
// Turns non-zero classifier samples into timestamped spike events, applies a refractory
// window and buffers events in a FWFT FIFO. Optional per-class counters: SPIKE_STATS_EN.
module spike_event_fifo #(
  parameter int TS_WIDTH   = 16,
  parameter int REFRACT    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 nn_valid,
  input  logic [1:0]           nn_class,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [1:0]           ev_class,
  output logic [TS_WIDTH-1:0]  ev_time,
  output logic                 fifo_full,
  output logic [CNT_WIDTH-1:0] overflow_cnt
`ifdef SPIKE_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [15:0]          stat_c1,
  output logic [15:0]          stat_c2,
  output logic [15:0]          stat_c3
`endif
);

  // state | meaning
  // IDLE  | eligible: next valid non-zero class becomes an event
  // REFR  | refractory: rcnt valid samples still to be ignored
  typedef enum logic {IDLE, REFR} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  state_t               state;
  logic [RW-1:0]        rcnt;
  logic [TS_WIDTH-1:0]  ts;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [1:0]           mem_class [FIFO_DEPTH];
  logic [TS_WIDTH-1:0]  mem_time  [FIFO_DEPTH];
  logic [1:0]           hold_class;
  logic [TS_WIDTH-1:0]  hold_time;
  logic                 empty, full, ev_gen, pop, push_ok, drop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign ev_gen  = nn_valid && (state == IDLE) && (nn_class != 2'd0);
  assign pop     = !empty && ev_ready;
  assign push_ok = ev_gen && (!full || pop);
  assign drop    = ev_gen && full && !pop;

  assign ev_valid  = !empty;
  assign fifo_full = full;
  // When empty, present the last popped head so the outputs stay stable.
  assign ev_class  = empty ? hold_class : mem_class[rd_ptr[AW-1:0]];
  assign ev_time   = empty ? hold_time  : mem_time[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rcnt  <= '0;
      ts    <= '0;
    end else if (nn_valid) begin
      ts <= ts + 1'b1;
      case (state)
        IDLE: begin
          if ((nn_class != 2'd0) && (REFRACT != 0)) begin
            state <= REFR;
            rcnt  <= RW'(REFRACT);
          end
        end
        REFR: begin
          // The sample reaching terminal count is itself ignored.
          if (rcnt == RW'(1)) state <= IDLE;
          rcnt <= rcnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_class[wr_ptr[AW-1:0]] <= nn_class;
      mem_time[wr_ptr[AW-1:0]]  <= ts;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      hold_class   <= '0;
      hold_time    <= '0;
      overflow_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        hold_class <= mem_class[rd_ptr[AW-1:0]];
        hold_time  <= mem_time[rd_ptr[AW-1:0]];
      end
      if (drop && (overflow_cnt != {CNT_WIDTH{1'b1}}))
        overflow_cnt <= overflow_cnt + 1'b1;
    end
  end

`ifdef SPIKE_STATS_EN
  // Counts every generated event, dropped or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_c1 <= '0;
      stat_c2 <= '0;
      stat_c3 <= '0;
    end else if (stat_clr) begin
      stat_c1 <= '0;
      stat_c2 <= '0;
      stat_c3 <= '0;
    end else if (ev_gen) begin
      case (nn_class)
        2'd1: if (stat_c1 != 16'hFFFF) stat_c1 <= stat_c1 + 1'b1;
        2'd2: if (stat_c2 != 16'hFFFF) stat_c2 <= stat_c2 + 1'b1;
        2'd3: if (stat_c3 != 16'hFFFF) stat_c3 <= stat_c3 + 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_spike_event_fifo.sv
// Scoreboard bench for spike_event_fifo with REFRACT=4, FIFO_DEPTH=4.
module tb_spike_event_fifo;
  localparam int TSW = 16;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           nn_valid = 1'b0;
  logic [1:0]     nn_class = 2'd0;
  logic           ev_valid;
  logic           ev_ready = 1'b1;
  logic [1:0]     ev_class;
  logic [TSW-1:0] ev_time;
  logic           fifo_full;
  logic [CW-1:0]  overflow_cnt;
`ifdef SPIKE_STATS_EN
  logic           stat_clr = 1'b0;
  logic [15:0]    stat_c1, stat_c2, stat_c3;
`endif

  int tests = 0;
  int fails = 0;
  logic [TSW+1:0] sb[$];

  spike_event_fifo #(.TS_WIDTH(TSW), .REFRACT(4), .FIFO_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .nn_valid(nn_valid), .nn_class(nn_class),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_class(ev_class), .ev_time(ev_time),
    .fifo_full(fifo_full), .overflow_cnt(overflow_cnt)
`ifdef SPIKE_STATS_EN
    , .stat_clr(stat_clr), .stat_c1(stat_c1), .stat_c2(stat_c2), .stat_c3(stat_c3)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops one expected event.
  always @(negedge clk) begin
    if (rst && ev_valid && ev_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got class %0d time %0d expected none", ev_class, ev_time);
      end else begin
        logic [TSW+1:0] e;
        e = sb.pop_front();
        if ({ev_class, ev_time} !== e) begin
          fails++;
          $display("FAIL event: got class %0d time %0d expected class %0d time %0d",
                   ev_class, ev_time, e[TSW+1:TSW], e[TSW-1:0]);
        end
      end
    end
  end

  // Inputs are set at edge+1 and consumed by the next rising edge.
  task automatic step(input logic v, input logic [1:0] c);
    nn_valid = v;
    nn_class = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [1:0] c, input int t);
    sb.push_back({c, TSW'(t)});
  endtask

  task automatic do_reset();
    nn_valid = 1'b0;
    nn_class = 2'd0;
    rst = 1'b0;
    #2;
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_class", ev_class, 0);
    chk("rst_ev_time", ev_time, 0);
    chk("rst_fifo_full", fifo_full, 0);
    chk("rst_overflow", overflow_cnt, 0);
    sb.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    ev_ready = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0);
    chk("drain_empty", ev_valid, 0);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    @(posedge clk);
    #1;

    // single event with latency 1
    do_reset();
    step(1'b1, 2'd0);
    step(1'b1, 2'd0);
    chk("s1_pre_valid", ev_valid, 0);
    expect_ev(2'd2, 2);
    step(1'b1, 2'd2);
    chk("s1_latency_valid", ev_valid, 1);
    chk("s1_head_time", ev_time, 2);
    step(1'b1, 2'd0);
    chk("s1_popped", ev_valid, 0);
    chk("s1_hold_time", ev_time, 2);

    // refractory window
    do_reset();
    expect_ev(2'd1, 0);
    step(1'b1, 2'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd3);
    expect_ev(2'd2, 5);
    step(1'b1, 2'd2);
    drain(3);

    // same with gaps; class on invalid cycles must be ignored
    do_reset();
    expect_ev(2'd1, 0);
    step(1'b1, 2'd1);
    step(1'b0, 2'd0);
    step(1'b1, 2'd3);
    step(1'b0, 2'd3);
    step(1'b1, 2'd3);
    step(1'b1, 2'd3);
    step(1'b0, 2'd2);
    step(1'b1, 2'd3);
    step(1'b0, 2'd0);
    expect_ev(2'd2, 5);
    step(1'b1, 2'd2);
    drain(3);

    // overflow with consumer stalled
    do_reset();
    ev_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) expect_ev(2'd1, k * 5);
      step(1'b1, 2'd1);
      for (int j = 0; j < 4; j++) step(1'b1, 2'd0);
    end
    chk("ovf_full", fifo_full, 1);
    chk("ovf_cnt", overflow_cnt, 2);
    chk("ovf_head_time", ev_time, 0);
    drain(6);
    chk("ovf_full_after", fifo_full, 0);
    chk("ovf_cnt_hold", overflow_cnt, 2);

    // full FIFO with simultaneous push and pop
    do_reset();
    ev_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_ev(2'd1, k * 5);
      step(1'b1, 2'd1);
      for (int j = 0; j < 4; j++) step(1'b1, 2'd0);
    end
    chk("pp_full_before", fifo_full, 1);
    ev_ready = 1'b1;
    expect_ev(2'd2, 20);
    step(1'b1, 2'd2);
    chk("pp_full_kept", fifo_full, 1);
    chk("pp_ovf_unchanged", overflow_cnt, 0);
    chk("pp_new_head", ev_time, 5);
    drain(6);

    // async reset with events buffered and refractory active
    do_reset();
    ev_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_ev(2'd1, k * 5);
      step(1'b1, 2'd1);
      if (k < 2) for (int j = 0; j < 4; j++) step(1'b1, 2'd0);
    end
    step(1'b1, 2'd0);
    chk("ar_buffered", ev_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_ev_valid", ev_valid, 0);
    chk("ar_overflow", overflow_cnt, 0);
    chk("ar_full", fifo_full, 0);
    sb.delete();
    #1;
    rst = 1'b1;
    nn_valid = 1'b0;
    @(posedge clk);
    #1;
    ev_ready = 1'b1;
    expect_ev(2'd3, 0);
    step(1'b1, 2'd3);
    chk("ar_first_valid", ev_valid, 1);
    chk("ar_first_time", ev_time, 0);
    drain(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
